// File: rtl/fact_accel.sv
// fact_accel: memory-mapped factorial accelerator on the core data bus.
//   Computes n! iteratively, one multiply per clock.
//   Latency: done rises max(n,1) edges after the GO write; the error path takes 1 edge.
//   Backpressure: none. A GO write while a run is in progress is dropped.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low; clears all state
//   sel        - chip select from the address decoder
//   addr       - word offset: 0=N, 1=GO, 2=STATUS, 3=RESULT
//   WE         - write enable, qualified by sel
//   write_data - bus write data
//   data_out   - combinational read data; zero unless sel=1 and WE=0
//   done       - completion flag, mirrors STATUS[0]
// Build option FACT_RD_CLR_EN: a RESULT read sampled at an edge in DONE or ERR
//   clears done/err and returns the FSM to IDLE. P is kept.
module fact_accel #(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int N_MAX      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [1:0]            addr,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_GO     = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  // One extra bit so an N_MAX at the top of the operand range still compares correctly.
  localparam logic [N_WIDTH:0] N_MAX_W = N_MAX[N_WIDTH:0];

  state_t                state_q;
  logic [N_WIDTH-1:0]    n_q;
  logic [N_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0] p_q;
  logic [DATA_WIDTH-1:0] p_d;
  logic                  done_q;
  logic                  err_q;
  logic                  busy_q;

  logic n_wr;
  logic go_wr;
  logic n_too_big;
`ifdef FACT_RD_CLR_EN
  logic res_rd;
`endif

  // Only the low N_WIDTH bits of the bus are stored in N; bit 0 alone is used for GO.
  logic unused_wdata;
  assign unused_wdata = ^write_data[DATA_WIDTH-1:N_WIDTH];

  assign n_wr      = sel && WE && (addr == A_N);
  assign go_wr     = sel && WE && (addr == A_GO) && write_data[0];
  assign n_too_big = ({1'b0, n_q} > N_MAX_W);
`ifdef FACT_RD_CLR_EN
  assign res_rd    = sel && !WE && (addr == A_RESULT);
`endif

  // Product truncated to the bus width; cnt is zero-extended before the multiply.
  assign p_d = p_q * DATA_WIDTH'(cnt_q);

  // The N register is writable in every state; a running computation only sees cnt_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q <= '0;
    end else if (n_wr) begin
      n_q <= write_data[N_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_BUSY: begin
          // GO writes are ignored here by construction.
          if (cnt_q <= N_WIDTH'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            p_q   <= p_d;
            cnt_q <= cnt_q - N_WIDTH'(1);
          end
        end
        default: begin
          // IDLE, DONE and ERR all accept a new GO.
          if (go_wr) begin
            if (n_too_big) begin
              state_q <= S_ERR;
              p_q     <= '0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_BUSY;
              p_q     <= DATA_WIDTH'(1);
              cnt_q   <= n_q;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
`ifdef FACT_RD_CLR_EN
          else if (res_rd && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (sel && !WE) begin
      case (addr)
        A_N:      data_out = DATA_WIDTH'(n_q);
        A_GO:     data_out = '0;
        A_STATUS: data_out = DATA_WIDTH'({busy_q, err_q, done_q});
        A_RESULT: data_out = p_q;
        default:  data_out = '0;
      endcase
    end
  end

  assign done = done_q;

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator in the SoC, next to the MIPS core's data bus. The core writes an operand n and a GO command. The block computes n! iteratively, one multiply per clock, and raises `done` (the SoC's `faccel_done` line). The core polls STATUS and reads RESULT through the SoC read mux.

## Interface
Parameters:
- `DATA_WIDTH`, 32: result / bus data width.
- `N_WIDTH`, 4: operand register width (n = 0..15).
- `N_MAX`, 12: largest n whose factorial fits in `DATA_WIDTH`; n > `N_MAX` is an error.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; the low level clears all state immediately.
- `sel` input 1: chip select from the SoC address decoder.
- `addr` input 2: word offset (bus addr[3:2]). 0 = N, 1 = GO, 2 = STATUS, 3 = RESULT.
- `WE` input 1: write enable, qualified by `sel`.
- `write_data` input `DATA_WIDTH`: bus write data.
- `data_out` output `DATA_WIDTH`: read data, combinational.
- `done` output 1: completion flag, same as STATUS[0].

## Operation
Register map:
- **N (R/W):** low `N_WIDTH` bits of `write_data`; reads zero-extended.
- **GO (W):** a write with `write_data[0]`=1 starts a run. Reads return 0.
- **STATUS (R):** {29'b0, busy, err, done}.
- **RESULT (R):** product register P.

FSM states: IDLE, BUSY, DONE, ERR.
- **Start:** a GO write in IDLE, DONE or ERR starts a run. At that edge, done and err clear.
  - If N > `N_MAX`: go to ERR with err=1, done=1, P=0.
  - Otherwise: go to BUSY with P=1 and cnt=N. cnt is internal, `N_WIDTH` wide.
- **BUSY, each edge:**
  - If cnt ≤ 1: go to DONE, done=1.
  - Else: P ← P·cnt (low `DATA_WIDTH` bits) and cnt ← cnt−1.
- **GO write while BUSY:** ignored.
- **N write while BUSY:** updates N only; the running computation uses the latched cnt.
- **GO with write_data[0]=0:** no effect.
- **Write to STATUS or RESULT:** no effect.
- **Read of GO:** returns 0.
- `data_out` = 0 whenever `sel`=0 or `WE`=1.
- **Reset (any state, including mid-run):** state=IDLE; N, P, cnt=0; done=0, err=0, busy=0. Therefore `data_out`=0 and `done`=0.

## Timing
- A GO write registered at edge T sets busy=1 after edge T.
- `done` rises after edge T+max(N,1), with RESULT valid at the same time. Examples: n=0 or 1 → T+1; n=5 → T+5; n=12 → T+12.
- Error path: err=done=1 after edge T itself; busy never asserts.
- `done` holds until the next GO or reset, except under `FACT_RD_CLR_EN`.
- Reads are combinational: `data_out` reflects register state in the same cycle `sel`/`addr` are presented.
- A GO write and a completion edge cannot coincide, because GO is ignored in BUSY.
- A GO write in DONE restarts the run on that edge; done drops after that edge.

## Configuration
- **`FACT_RD_CLR_EN` defined:** a RESULT read (`sel`=1, `WE`=0, `addr`=3) sampled at a clock edge in DONE or ERR clears done and err and returns the FSM to IDLE. P is retained and `data_out` still shows P during that read cycle.
- **`FACT_RD_CLR_EN` undefined:** reads have no side effects; done/err are cleared only by GO or reset.

## Test plan
- **Reset values:** hold `reset`=0 mid-run (n=10, 3 cycles after GO) → `done`=0, STATUS=0, RESULT=0, N=0 immediately; after release the FSM is IDLE.
- **n=5:** write N=5, GO=1 → busy=1 for 5 edges, then `done`=1, RESULT=0x00000078, STATUS=0x1.
- **n=0 and n=1:** each → `done` after 1 edge, RESULT=1.
- **n=12 then n=13:**
  - n=12 → `done` at T+12, RESULT=0x1C8CFC00.
  - n=13 → at T+1, STATUS=0x3, RESULT=0.
- **Busy interference:** during an n=6 run, write GO=1 and N=3.
  - The run finishes with RESULT=720 (0x2D0).
  - A following GO then computes 3! = 6.
- **Macro on/off:** after n=4 completes, read RESULT.
  - Defined → 0x18 returned, STATUS=0 on the next cycle.
  - Undefined → STATUS stays 0x1 across repeated reads.
